// File: rtl/ms_display_pkg.sv
// Shared definitions for the millisecond display: 7-segment encodings,
// digit count and the sequential BCD converter state enumeration.
package ms_display_pkg;

  localparam int unsigned NUM_DIGITS = 3;

  // Active-low segments, bit0 = a ... bit6 = g.
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Entry n holds the pattern for decimal digit n.
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StLoad
  } conv_state_e;

  // Non-decimal nibbles light nothing rather than a misleading glyph.
  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    if (nib > 4'd9) begin
      return SEG_OFF;
    end
    return SEG_DIGITS[nib];
  endfunction

endpackage

// File: rtl/ms_display_bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter. One adjust+shift step per
// clock for BinWidth clocks, then one LOAD clock that publishes the result.
module bin2bcd_seq
  import ms_display_pkg::*;
#(
  parameter int unsigned BinWidth  = 10,
  parameter int unsigned NumDigits = NUM_DIGITS
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [BinWidth-1:0]      value_i,
  output logic                     busy_o,
  output logic [4*NumDigits-1:0]   bcd_o
);

  localparam int unsigned BcdW = 4 * NumDigits;
  localparam int unsigned SrW  = BcdW + BinWidth;
  localparam int unsigned CntW = $clog2(BinWidth);
  localparam logic [CntW-1:0] LastCnt = CntW'(BinWidth - 1);

  conv_state_e     state_q, state_d;
  logic [SrW-1:0]  sr_q, sr_d;
  logic [SrW-1:0]  adj;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [BcdW-1:0] bcd_q, bcd_d;

  // Converter state, shift register, step counter and published result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      sr_q    <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
    end
  end

  // Next-state: load on start, adjust-then-shift per step, publish in LOAD.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    adj     = sr_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          sr_d    = {{BcdW{1'b0}}, value_i};
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        for (int i = 0; i < int'(NumDigits); i++) begin
          if (adj[BinWidth+4*i +: 4] >= 4'd5) begin
            adj[BinWidth+4*i +: 4] = adj[BinWidth+4*i +: 4] + 4'd3;
          end
        end
        sr_d  = {adj[SrW-2:0], 1'b0};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        bcd_d   = sr_q[SrW-1 -: BcdW];
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy_o = (state_q != StIdle);
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/ms_display.sv
// ms_display: change-detects the binary millisecond value, clamps it, hands it
// to the sequential BCD converter and multiplexes the result onto a 3-digit
// active-low 7-segment display.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module ms_display
  import ms_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned MAX_VAL  = 999
) (
  input  logic        clk_50M,
  input  logic        rst_n,
  input  logic [9:0]  value_in,
  output logic [6:0]  seg_n,
  output logic [2:0]  an_n,
  output logic [11:0] bcd_out,
  output logic        conv_busy
);

  localparam int unsigned PreW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(SCAN_DIV - 1);
  localparam logic [9:0] MaxVal = 10'(MAX_VAL);

  logic [9:0]      last_val_q, last_val_d;
  logic [9:0]      clamped;
  logic            start;
  logic [PreW-1:0] pre_q, pre_d;
  logic            wrap;
  logic            active_q, active_d;
  logic [1:0]      dig_q, dig_d;
  logic [3:0]      nib;
  logic            blank;
  logic [6:0]      seg_q, seg_d;
  logic [2:0]      an_q, an_d;

  // last_val keeps the raw input so an over-range value is not re-converted forever.
  assign start   = !conv_busy && (value_in != last_val_q);
  assign clamped = (value_in > MaxVal) ? MaxVal : value_in;
  assign wrap    = (pre_q == PreLast);

  bin2bcd_seq #(
    .BinWidth  (10),
    .NumDigits (NUM_DIGITS)
  ) u_bin2bcd (
    .clk_i   (clk_50M),
    .rst_ni  (rst_n),
    .start_i (start),
    .value_i (clamped),
    .busy_o  (conv_busy),
    .bcd_o   (bcd_out)
  );

  // Change-detect and display scan state; seg/an registered together.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      last_val_q <= '0;
      pre_q      <= '0;
      active_q   <= 1'b0;
      dig_q      <= 2'd0;
      seg_q      <= SEG_OFF;
      an_q       <= 3'b111;
    end else begin
      last_val_q <= last_val_d;
      pre_q      <= pre_d;
      active_q   <= active_d;
      dig_q      <= dig_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  // Next-state for change-detect, prescaler, digit index and segment mux.
  always_comb begin
    last_val_d = start ? value_in : last_val_q;
    pre_d      = wrap ? '0 : pre_q + PreW'(1);
    active_d   = active_q | wrap;
    dig_d      = dig_q;
    // The first wrap only enables the display on digit 0; later wraps advance.
    if (wrap && active_q) begin
      dig_d = (dig_q == 2'd2) ? 2'd0 : dig_q + 2'd1;
    end
    case (dig_d)
      2'd0:    nib = bcd_out[3:0];
      2'd1:    nib = bcd_out[7:4];
      default: nib = bcd_out[11:8];
    endcase
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    blank = ((dig_d == 2'd2) && (bcd_out[11:8] == 4'd0)) ||
            ((dig_d == 2'd1) && (bcd_out[11:8] == 4'd0) && (bcd_out[7:4] == 4'd0));
`endif
    if (active_d) begin
      an_d  = ~(3'b001 << dig_d);
      seg_d = blank ? SEG_OFF : seg_encode(nib);
    end else begin
      an_d  = 3'b111;
      seg_d = SEG_OFF;
    end
  end

  assign seg_n = seg_q;
  assign an_n  = an_q;

endmodule

// File: tb/tb_ms_display.sv
// Self-checking bench for ms_display: a cycle-level behavioural model checked
// every negedge, plus directed scenarios with hand-computed expectations and a
// randomized phase.
module tb_ms_display;

  localparam int DIV = 8;

  logic        clk_50M = 1'b0;
  logic        rst_n;
  logic [9:0]  value_in;
  logic [6:0]  seg_n;
  logic [2:0]  an_n;
  logic [11:0] bcd_out;
  logic        conv_busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  ms_display #(
    .SCAN_DIV (DIV),
    .MAX_VAL  (999)
  ) dut (
    .clk_50M   (clk_50M),
    .rst_n     (rst_n),
    .value_in  (value_in),
    .seg_n     (seg_n),
    .an_n      (an_n),
    .bcd_out   (bcd_out),
    .conv_busy (conv_busy)
  );

  always #5 clk_50M = ~clk_50M;

  function automatic logic [9:0] clampv(input logic [9:0] v);
    return (v > 10'd999) ? 10'd999 : v;
  endfunction

  function automatic logic [11:0] to_bcd(input logic [9:0] v);
    int x;
    x = int'(v);
    return {4'(x / 100), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Display after edge number cyc since reset release: one slot per DIV edges.
  function automatic logic [2:0] exp_an_f(input int cyc);
    int w;
    w = cyc / DIV;
    if (w == 0) return 3'b111;
    return ~(3'b001 << ((w - 1) % 3));
  endfunction

  function automatic logic [6:0] exp_seg_f(input int cyc, input logic [11:0] b);
    int w;
    int d;
    logic [3:0] h, t, o;
    w = cyc / DIV;
    if (w == 0) return 7'h7F;
    d = (w - 1) % 3;
    h = b[11:8];
    t = b[7:4];
    o = b[3:0];
`ifdef LEADING_ZERO_BLANK_EN
    if (d == 2 && h == 4'd0) return 7'h7F;
    if (d == 1 && h == 4'd0 && t == 4'd0) return 7'h7F;
`endif
    if (d == 0) return seg_of(o);
    if (d == 1) return seg_of(t);
    return seg_of(h);
  endfunction

  // Behavioural model: a conversion occupies 11 busy clocks, result lands on the last.
  logic [9:0]  m_last  = '0;
  logic [9:0]  m_pend  = '0;
  int          m_cnt   = 0;
  int          m_cyc   = 0;
  logic [11:0] m_bcd   = '0;
  logic [6:0]  exp_seg = 7'h7F;
  logic [2:0]  exp_an  = 3'b111;

  always @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      m_last  <= '0;
      m_pend  <= '0;
      m_cnt   <= 0;
      m_cyc   <= 0;
      m_bcd   <= '0;
      exp_seg <= 7'h7F;
      exp_an  <= 3'b111;
    end else begin
      m_cyc   <= m_cyc + 1;
      exp_an  <= exp_an_f(m_cyc + 1);
      exp_seg <= exp_seg_f(m_cyc + 1, m_bcd);
      if (m_cnt == 1) m_bcd <= to_bcd(clampv(m_pend));
      if (m_cnt == 0) begin
        if (value_in != m_last) begin
          m_last <= value_in;
          m_pend <= value_in;
          m_cnt  <= 11;
        end
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 20) $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk_50M) begin
    if (chk_en) begin
      check("cyc_seg_n", 32'(seg_n), 32'(exp_seg));
      check("cyc_an_n", 32'(an_n), 32'(exp_an));
      check("cyc_bcd_out", 32'(bcd_out), 32'(m_bcd));
      check("cyc_conv_busy", 32'(conv_busy), 32'(m_cnt != 0));
    end
  end

  task automatic apply(input logic [9:0] v);
    @(negedge clk_50M);
    value_in = v;
  endtask

  logic [6:0] seen0, seen1, seen2;

  // Capture the segment pattern shown on each digit over a full scan.
  task automatic capture_digits();
    seen0 = 7'h7F;
    seen1 = 7'h7F;
    seen2 = 7'h7F;
    for (int i = 0; i < 4 * DIV; i++) begin
      @(negedge clk_50M);
      if (an_n == 3'b110) seen0 = seg_n;
      if (an_n == 3'b101) seen1 = seg_n;
      if (an_n == 3'b011) seen2 = seg_n;
    end
  endtask

  int busy_cnt;

  initial begin
    rst_n    = 1'b0;
    value_in = 10'd0;
    repeat (3) @(posedge clk_50M);
    #1;
    chk_en = 1'b1;
    check("rst_an_n", 32'(an_n), 32'h7);
    check("rst_seg_n", 32'(seg_n), 32'h7F);
    check("rst_bcd_out", 32'(bcd_out), 32'h0);
    check("rst_busy", 32'(conv_busy), 32'h0);
    @(negedge clk_50M);
    rst_n = 1'b1;

    // Zero value: display blank until first wrap, then 110/101/011 with "0".
    for (int e = 1; e <= 3 * DIV; e++) begin
      @(posedge clk_50M);
      #1;
      if (e == DIV - 1) check("pre_wrap_an", 32'(an_n), 32'h7);
      if (e == DIV) check("slot0_an", 32'(an_n), 32'h6);
      if (e == 2 * DIV) check("slot1_an", 32'(an_n), 32'h5);
      if (e == 3 * DIV) check("slot2_an", 32'(an_n), 32'h3);
`ifndef LEADING_ZERO_BLANK_EN
      if (e % DIV == 0) check("zero_seg", 32'(seg_n), 32'h40);
`endif
    end
    check("zero_bcd", 32'(bcd_out), 32'h000);

    // 0 -> 437: 11 busy clocks, result on the 12th edge.
    apply(10'd437);
    busy_cnt = 0;
    for (int e = 1; e <= 14; e++) begin
      @(posedge clk_50M);
      #1;
      if (conv_busy) busy_cnt++;
      if (e == 11) check("437_before", 32'(bcd_out), 32'h000);
      if (e == 12) check("437_at12", 32'(bcd_out), 32'h437);
    end
    check("437_busy_cycles", 32'(busy_cnt), 32'd11);
    capture_digits();
    check("437_ones", 32'(seen0), 32'h78);
    check("437_tens", 32'(seen1), 32'h30);
    check("437_hund", 32'(seen2), 32'h19);

    // Over-range clamps to 999.
    apply(10'd1023);
    repeat (12) @(posedge clk_50M);
    #1;
    check("1023_clamp", 32'(bcd_out), 32'h999);
    repeat (4) @(posedge clk_50M);

    // Change mid-conversion: 100 shown first, then 101.
    apply(10'd100);
    for (int e = 1; e <= 24; e++) begin
      @(posedge clk_50M);
      #1;
      if (e == 3) begin
        @(negedge clk_50M);
        value_in = 10'd101;
      end
      if (e == 12) check("mid_first", 32'(bcd_out), 32'h100);
      if (e == 24) check("mid_final", 32'(bcd_out), 32'h101);
    end
    repeat (4) @(posedge clk_50M);

    // Reset during SHIFT of 512.
    apply(10'd512);
    repeat (5) @(posedge clk_50M);
    #2;
    check("abort_busy_pre", 32'(conv_busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("abort_bcd", 32'(bcd_out), 32'h0);
    check("abort_busy", 32'(conv_busy), 32'h0);
    check("abort_an", 32'(an_n), 32'h7);
    check("abort_seg", 32'(seg_n), 32'h7F);
    repeat (2) @(posedge clk_50M);
    @(negedge clk_50M);
    rst_n = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk_50M);
      #1;
      if (e == 11) check("abort_hold0", 32'(bcd_out), 32'h0);
      if (e == 12) check("abort_reconv", 32'(bcd_out), 32'h512);
    end

`ifdef LEADING_ZERO_BLANK_EN
    apply(10'd7);
    repeat (12) @(posedge clk_50M);
    capture_digits();
    check("lzb7_ones", 32'(seen0), 32'h78);
    check("lzb7_tens", 32'(seen1), 32'h7F);
    check("lzb7_hund", 32'(seen2), 32'h7F);
    apply(10'd0);
    repeat (12) @(posedge clk_50M);
    capture_digits();
    check("lzb0_ones", 32'(seen0), 32'h40);
    check("lzb0_tens", 32'(seen1), 32'h7F);
`endif

    // Randomized value stream, frequently changing mid-conversion.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk_50M);
      case ($urandom_range(0, 15))
        0:       value_in = 10'($urandom_range(0, 1023));
        1:       value_in = 10'($urandom_range(1000, 1023));
        2:       value_in = 10'($urandom_range(0, 9));
        default: ;
      endcase
    end
    repeat (30) @(posedge clk_50M);
    #1;
    check("final_newest", 32'(bcd_out), 32'(to_bcd(clampv(value_in))));

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
